// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Fills instruction memory from a byte stream so the CPU can fetch by PC later.
// Stream format: 16-bit big-endian word count N, then N big-endian 24-bit
// instructions (3 bytes each). One memory write is issued per instruction at
// BASE_ADDR, BASE_ADDR+1, ... The CPU fetch stage is held off while loading.
//
// Ports:
//   Clock, Reset      rising-edge clock, synchronous active-high reset
//   Start             one-cycle pulse; begins a load from IDLE, DONE or ERR
//   InByte/InValid/   byte stream input
//   InReady
//   WrEn/WrAddr/      instruction memory write port (registered, 1-cycle pulse)
//   WrData
//   Busy, CpuHold     load in progress (including the trailing write cycle)
//   Done, Error       sticky completion / length-overflow flags
//   WordsWritten      words written in the current or last load
//   dbg_state         current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where InValid & InReady are
// both 1. InReady depends only on the current state, never on InValid.
// InValid may be held low for any number of cycles; the loader just waits.
// -----------------------------------------------------------------------------
module program_loader #(
  parameter logic [23:0] BASE_ADDR = 24'd0,
  parameter int          DEPTH_W   = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  InByte,
  input  logic        InValid,
  output logic        InReady,
  output logic        WrEn,
  output logic [23:0] WrAddr,
  output logic [23:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [15:0] WordsWritten,
  output logic        CpuHold,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    B0     = 3'd3,
    B1     = 3'd4,
    B2     = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  // Largest accepted word count; 17 bits so 2^16 is representable.
  localparam logic [16:0] MAX_WORDS = 17'(1) << DEPTH_W;

  state_t      state;
  logic [15:0] len;
  logic [7:0]  byte0;
  logic [7:0]  byte1;
  logic        xfer;
  logic [15:0] len_next;
  logic        last_word;

  assign InReady   = (state == LEN_HI) || (state == LEN_LO) ||
                     (state == B0) || (state == B1) || (state == B2);
  assign xfer      = InValid && InReady;
  assign len_next  = {len[15:8], InByte};
  // WordsWritten still holds the pre-increment count during the B2 transfer.
  assign last_word = ((WordsWritten + 16'd1) == len);

  // Busy covers the streaming states plus the cycle the final write is on
  // the bus (state already DONE, WrEn still high).
  assign Busy      = InReady || WrEn;
  assign CpuHold   = Busy;
  assign dbg_state = state;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      len          <= 16'd0;
      byte0        <= 8'd0;
      byte1        <= 8'd0;
      WrEn         <= 1'b0;
      WrAddr       <= 24'd0;
      WrData       <= 24'd0;
      Done         <= 1'b0;
      Error        <= 1'b0;
      WordsWritten <= 16'd0;
    end else begin
      WrEn <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (Start) begin
            state        <= LEN_HI;
            Done         <= 1'b0;
            Error        <= 1'b0;
            WordsWritten <= 16'd0;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len[15:8] <= InByte;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len[7:0] <= InByte;
            if (len_next == 16'd0) begin
              state <= DONE;
              Done  <= 1'b1;
            end else if ({1'b0, len_next} > MAX_WORDS) begin
              state <= ERR;
              Error <= 1'b1;
            end else begin
              state <= B0;
            end
          end
        end
        B0: begin
          if (xfer) begin
            byte0 <= InByte;
            state <= B1;
          end
        end
        B1: begin
          if (xfer) begin
            byte1 <= InByte;
            state <= B2;
          end
        end
        B2: begin
          if (xfer) begin
            WrEn         <= 1'b1;
            WrData       <= {byte0, byte1, InByte};
            WrAddr       <= BASE_ADDR + 24'(WordsWritten);
            WordsWritten <= WordsWritten + 16'd1;
            if (last_word) begin
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              state <= B0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Table of load scenarios plus hand-written corner sequences. Expected memory
// writes come from a stream-level model (header -> N words -> addr/data list)
// and are checked against every WrEn pulse by a queue scoreboard.
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam logic [23:0] BASE = 24'd0;
  localparam int          DW   = 8;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [7:0]  InByte;
  logic        InValid;
  logic        InReady;
  logic        WrEn;
  logic [23:0] WrAddr;
  logic [23:0] WrData;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [15:0] WordsWritten;
  logic        CpuHold;
  logic [2:0]  dbg_state;

  program_loader #(.BASE_ADDR(BASE), .DEPTH_W(DW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .InByte(InByte),
    .InValid(InValid), .InReady(InReady), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .Busy(Busy), .Done(Done), .Error(Error),
    .WordsWritten(WordsWritten), .CpuHold(CpuHold), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    logic [47:0] e;
    if (WrEn === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", WrAddr, WrData);
      end else begin
        e = exp_q.pop_front();
        check("write_addr_data", {16'd0, WrAddr, WrData}, {16'd0, e});
      end
    end
  end

  // ---------------- reference model ----------------
  // Given a header count and payload, queue the writes memory should see and
  // return how many there are. Oversized or zero loads produce none.
  function automatic int model_load(input logic [15:0] n, input logic [7:0] pay[$]);
    int cnt;
    cnt = 0;
    if (n != 0 && int'(n) <= (1 << DW)) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_q.push_back({BASE + 24'(i), pay[3*i], pay[3*i+1], pay[3*i+2]});
        cnt++;
      end
    end
    return cnt;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps);
    int waited;
    waited = 0;
    for (int g = 0; g < gaps; g++) begin
      InValid = 1'b0;
      tick();
    end
    InValid = 1'b1;
    InByte  = b;
    while (InReady !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got InReady %0b expected 1 within 50 cycles", InReady);
    end
    tick();
    InValid = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {9'd0, InReady, WrEn, WrAddr, WrData, Busy, Done, Error, WordsWritten, CpuHold};
  endfunction

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] n;
    int          gap_mode;   // 0 back-to-back, 1 alternate stall, 2 random stall
    bit          rand_data;
    logic        exp_done;
    logic        exp_err;
    logic [15:0] exp_words;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [7:0] hdr_pay[$];
    logic [7:0] stream[$];
    logic [7:0] nominal[$];
    int nexp;
    int wr0;
    int t0;
    int gaps;

    nominal = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};

    tbl[0] = '{16'd2,      0, 1'b0, 1'b1, 1'b0, 16'd2};
    tbl[1] = '{16'd2,      1, 1'b0, 1'b1, 1'b0, 16'd2};
    tbl[2] = '{16'd0,      0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[3] = '{16'd257,    0, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[4] = '{16'd256,    0, 1'b1, 1'b1, 1'b0, 16'd256};
    tbl[5] = '{16'd5,      2, 1'b1, 1'b1, 1'b0, 16'd5};
    tbl[6] = '{16'd1,      0, 1'b1, 1'b1, 1'b0, 16'd1};
    tbl[7] = '{16'hFFFF,   0, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[8] = '{16'd7,      1, 1'b1, 1'b1, 1'b0, 16'd7};

    Reset = 1'b1; Start = 1'b0; InValid = 1'b0; InByte = 8'h00;
    repeat (3) tick();
    Reset = 1'b0;
    check("reset_outputs", all_outs(), 64'd0);
    tick();
    check("idle_outputs", all_outs(), 64'd0);

    // ---------- table-driven loads ----------
    for (int v = 0; v < 9; v++) begin
      pulse_start();
      check("start_clears", {44'd0, Busy, Done, Error, WordsWritten}, {44'd0, 1'b1, 1'b0, 1'b0, 16'd0});

      hdr_pay.delete();
      if (tbl[v].n != 0 && int'(tbl[v].n) <= (1 << DW)) begin
        for (int i = 0; i < 3 * int'(tbl[v].n); i++)
          hdr_pay.push_back(tbl[v].rand_data ? 8'($urandom_range(0, 255)) : nominal[i]);
      end
      nexp = model_load(tbl[v].n, hdr_pay);
      stream = hdr_pay;
      stream.push_front(tbl[v].n[7:0]);
      stream.push_front(tbl[v].n[15:8]);

      wr0 = wr_count;
      t0  = cyc;
      foreach (stream[i]) begin
        case (tbl[v].gap_mode)
          0:       gaps = 0;
          1:       gaps = (i % 2 == 1) ? 1 : 0;
          default: gaps = $urandom_range(0, 2);
        endcase
        send_byte(stream[i], gaps);
      end
      if (tbl[v].gap_mode == 0)
        check("throughput_cycles", 64'(cyc - t0), 64'(stream.size()));

      // Cycle right after the last transfer edge.
      if (tbl[v].exp_err)
        check("err_immediate", {60'd0, Error, Done, Busy, InReady}, {60'd0, 4'b1000});
      else if (tbl[v].n == 0)
        check("zero_len_done", {44'd0, Done, Busy, WrEn, InReady, WordsWritten},
              {44'd0, 4'b1000, 16'd0});
      else
        check("trailing_write", {44'd0, Done, Busy, WrEn, InReady, WordsWritten},
              {44'd0, 4'b1110, tbl[v].n});
      tick();
      check("busy_drops", {62'd0, Busy, CpuHold}, 64'd0);

      // Bytes offered while not ready must be ignored.
      InValid = 1'b1;
      InByte  = 8'h5A;
      repeat (4) tick();
      InValid = 1'b0;
      check("final_status", {46'd0, Done, Error, WordsWritten},
            {46'd0, tbl[v].exp_done, tbl[v].exp_err, tbl[v].exp_words});
      check("write_count", 64'(wr_count - wr0), 64'(nexp));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
    end

    // ---------- reset mid-stream ----------
    pulse_start();
    hdr_pay = '{8'h12, 8'h34, 8'h56};
    nexp = model_load(16'd1, hdr_pay);
    wr0 = wr_count;
    stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h65};
    foreach (stream[i]) send_byte(stream[i], 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midreset_outputs", all_outs(), 64'd0);
    InValid = 1'b1;
    InByte  = 8'h77;
    repeat (6) tick();
    InValid = 1'b0;
    check("midreset_writes", 64'(wr_count - wr0), 64'(nexp));
    check("midreset_idle", all_outs(), 64'd0);

    // ---------- Start ignored while streaming ----------
    pulse_start();
    hdr_pay = '{8'h11, 8'h22, 8'h33};
    nexp = model_load(16'd1, hdr_pay);
    wr0 = wr_count;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    pulse_start();
    check("ignored_start", {62'd0, Busy, InReady}, {62'd0, 2'b11});
    send_byte(8'h22, 1);
    send_byte(8'h33, 0);
    tick();
    check("ignored_start_done", {46'd0, Done, Error, WordsWritten}, {46'd0, 2'b10, 16'd1});
    check("ignored_start_writes", 64'(wr_count - wr0), 64'(nexp));

    // ---------- Start and Reset together ----------
    Start = 1'b1;
    Reset = 1'b1;
    tick();
    Start = 1'b0;
    Reset = 1'b0;
    check("start_reset_outputs", all_outs(), 64'd0);
    tick();
    check("start_reset_stays_idle", {61'd0, dbg_state}, 64'd0);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer-side counterpart of the instruction memory: fills instruction memory from a byte stream so the CPU can later fetch by PC.
- Accepts a length header followed by big-endian 24-bit instructions.
- Assembles each instruction from 3 bytes and issues one write per instruction at incrementing word addresses.
- Holds the CPU off (CpuHold) while a load is in progress.

Parameters:
- BASE_ADDR, 24'd0, word address of the first instruction written.
- DEPTH_W, 8, log2 of instruction memory depth in words (256 words by default).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse that begins a load; ignored unless the state is IDLE, DONE or ERR.
- InByte  in  8  stream data byte.
- InValid  in  1  InByte is valid this cycle.
- InReady  out  1  loader accepts a byte this cycle; a transfer occurs when InValid & InReady.
- WrEn  out  1  instruction memory write strobe, one cycle per word.
- WrAddr  out  24  instruction memory word address.
- WrData  out  24  instruction word.
- Busy  out  1  load in progress.
- Done  out  1  sticky; load completed successfully.
- Error  out  1  sticky; header length exceeds memory depth.
- WordsWritten  out  16  number of words written in the current or last load.
- CpuHold  out  1  equal to Busy; holds the CPU fetch stage.

Behaviour:
- Reset: all outputs are 0 and the state goes to IDLE. This includes reset asserted mid-load: the partial word is discarded, no further WrEn is issued, and Done/Error are cleared.
- States: IDLE, LEN_HI, LEN_LO, B0, B1, B2, DONE, ERR.
- Start: from IDLE, DONE or ERR, Start moves to LEN_HI. Done, Error and WordsWritten clear in the same edge. Start in any other state is ignored.
- InReady is 1 only in LEN_HI, LEN_LO, B0, B1, B2. The state advances only on a transfer; InValid=0 stalls indefinitely with no timeout.
- LEN_HI: transfer latches N[15:8] and moves to LEN_LO.
- LEN_LO: transfer latches N[7:0]. Next state:
  - N = 0 → DONE.
  - N > 2^DEPTH_W → ERR.
  - Otherwise → B0.
- B0: transfer latches instruction bits [23:16]. B1: latches bits [15:8].
- B2: transfer latches bits [7:0] and schedules a write:
  - On the next cycle WrEn=1, WrData = assembled word, WrAddr = BASE_ADDR + WordsWritten (pre-increment value); WordsWritten increments on that same edge.
  - Write latency is 1 cycle after the third byte's transfer edge.
  - WrEn is a registered single-cycle pulse; it is 0 in all other cycles.
- After the B2 transfer:
  - If this was word N, go to DONE. WrEn still fires in the first DONE cycle, and Done asserts in that same cycle.
  - Otherwise return to B0. InReady stays 1, so the first byte of the next word can transfer in the same cycle WrEn is high. Sustained throughput is 1 word per 3 cycles.
- WrAddr arithmetic: 24-bit, wraps modulo 2^24. WrAddr and WrData hold their last values when WrEn=0.
- Busy = 1 in LEN_HI through B2, and also during the trailing write cycle. It drops to 0 the cycle after the last WrEn.
- DONE/ERR: InReady=0; Done or Error is held high until Reset or Start.
- Bytes presented while InReady=0 are not consumed.
- Boundary N = 2^DEPTH_W is accepted; the last word is written at BASE_ADDR + 2^DEPTH_W − 1.
- Start and Reset in the same cycle: Reset wins.

Test Plan:
- Reset mid-stream:
  - Stimulus: Start, stream 00 02, 12 34 56, then Reset after byte 65.
  - Required: exactly one WrEn (addr 0, data 24'h123456); all outputs 0 after the reset edge; no further writes.
- Nominal load:
  - Stimulus: Start, stream 00 02 12 34 56 AB CD EF with InValid held high.
  - Required: WrEn at addr 0 data 24'h123456, then addr 1 data 24'hABCDEF.
  - Required: InReady never drops between words; Done=1, WordsWritten=2, Busy=0, CpuHold=0 afterwards.
- Stalled stream:
  - Stimulus: same stream as the nominal load, InValid toggling 1/0 every cycle.
  - Required: same two writes with identical data; no byte skipped or duplicated.
- Zero length:
  - Stimulus: Start, stream 00 00.
  - Required: no WrEn; Done=1 one cycle after the second byte; WordsWritten=0.
- Overflow and recovery (DEPTH_W=8):
  - Stimulus: header 01 01 (N=257).
  - Required: Error=1, InReady=0, no writes.
  - Stimulus: then Start with header 01 00 and 768 bytes.
  - Required: Error clears; last write at addr 255; Done=1.
- Ignored Start:
  - Stimulus: Start pulse while in B1.
  - Required: no state change; load completes with correct data.
  - Stimulus: Start and Reset asserted together.
  - Required: IDLE, all outputs 0.
